// File: rtl/srrc_fir_par_if.sv
// ============================================================================
//  Module      : srrc_fir_par_if
//  Description : Sample, coefficient and status bundle for srrc_fir_par.
//                master = sample/coefficient source, slave = filter.
//  Ports       : sam_clk_en/x_in      sample strobe and signed sample
//                coef_we/addr/wdata   coefficient write port
//                err_clr              clears sticky error flags
//                y/y_valid            filtered sample and update pulse
//                busy/err             activity and sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface srrc_fir_par_if #(
  parameter int NTAPS = 81,
  parameter int DW    = 18,
  parameter int CW    = 18
);
  localparam int M   = (NTAPS + 1) / 2;
  localparam int AAW = (M > 1) ? $clog2(M) : 1;

  logic                  sam_clk_en;
  logic signed [DW-1:0]  x_in;
  logic                  coef_we;
  logic [AAW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_wdata;
  logic                  err_clr;
  logic signed [DW-1:0]  y;
  logic                  y_valid;
  logic                  busy;
  logic [1:0]            err;

  modport master (
    output sam_clk_en, x_in, coef_we, coef_addr, coef_wdata, err_clr,
    input  y, y_valid, busy, err
  );

  modport slave (
    input  sam_clk_en, x_in, coef_we, coef_addr, coef_wdata, err_clr,
    output y, y_valid, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/srrc_fir_par.sv
// ============================================================================
//  Module      : srrc_fir_par
//  Description : Symmetric odd-length SRRC FIR with runtime-loadable
//                coefficients. LANES pre-add/multiply lanes are time-shared
//                over P = ceil(M/LANES) issue cycles per accepted sample.
//  Ports       : clk    system clock
//                reset  asynchronous reset, active low
//                bus    srrc_fir_par_if.slave (sample in, coefficient
//                       write, y/y_valid out, busy, sticky err[1:0])
//  Options     : SRRC_ROUND_EN defined  -> round-half-up before output slice
//                SRRC_ROUND_EN undefined -> truncation
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module srrc_fir_par #(
  parameter int NTAPS = 81,
  parameter int DW    = 18,
  parameter int CW    = 18,
  parameter int LANES = 21,
  parameter int GUARD = 6
) (
  input  logic           clk,
  input  logic           reset,
  srrc_fir_par_if.slave  bus
);

  localparam int M   = (NTAPS + 1) / 2;
  localparam int P   = (M + LANES - 1) / LANES;
  localparam int AW  = DW + CW + 1 + GUARD;
  localparam int PW  = DW + CW + 1;
  localparam int SW  = AW - CW;
  localparam int JW  = (P > 1) ? $clog2(P) : 1;

`ifdef SRRC_ROUND_EN
  localparam logic signed [AW-1:0] ROUNDK = AW'(1) << (CW - 1);
`else
  localparam logic signed [AW-1:0] ROUNDK = '0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACC   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [JW-1:0]          j_q;
  logic signed [DW-1:0]   x_q    [NTAPS];
  logic signed [CW-1:0]   b_q    [M];
  logic signed [PW-1:0]   prod_q [LANES];
  logic signed [AW-1:0]   acc_q;
  logic signed [DW-1:0]   y_q;
  logic                   y_valid_q;
  logic                   busy_q;
  logic [1:0]             err_q;
  logic [1:0]             err_d;

  // Per-slot lane operands; slot s covers k = s*LANES .. s*LANES+LANES-1.
  logic signed [DW:0]     w_pre_s  [P][LANES];
  logic signed [CW-1:0]   w_coef_s [P][LANES];
  logic signed [DW:0]     w_pre    [LANES];
  logic signed [CW-1:0]   w_coef   [LANES];
  logic signed [PW-1:0]   w_prod   [LANES];
  logic signed [AW-1:0]   w_sum;
  logic signed [SW-1:0]   w_slice;
  logic signed [DW-1:0]   w_y_sat;
  logic                   w_unused_lsbs;
  logic                   w_addr_ok;
  logic                   w_overrun;
  logic                   w_collide;
  logic                   w_coef_wr;

  for (genvar s = 0; s < P; s++) begin : g_slot
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int K = s * LANES + l;
      if (K < M - 1) begin : g_pair
        assign w_pre_s[s][l]  = {x_q[K][DW-1], x_q[K]}
                              + {x_q[NTAPS-1-K][DW-1], x_q[NTAPS-1-K]};
        assign w_coef_s[s][l] = b_q[K];
      end else if (K == M - 1) begin : g_centre
        assign w_pre_s[s][l]  = {x_q[K][DW-1], x_q[K]};
        assign w_coef_s[s][l] = b_q[K];
      end else begin : g_pad
        assign w_pre_s[s][l]  = '0;
        assign w_coef_s[s][l] = '0;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_pre[l]  = '0;
      w_coef[l] = '0;
      for (int s = 0; s < P; s++) begin
        if (j_q == JW'(s)) begin
          w_pre[l]  = w_pre_s[s][l];
          w_coef[l] = w_coef_s[s][l];
        end
      end
      w_prod[l] = PW'(w_pre[l]) * PW'(w_coef[l]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = w_sum + AW'(prod_q[l]);
    end
  end

  // Output slice drops CW fractional bits; saturate if the guard bits
  // above the DW-bit result are not a pure sign extension.
  assign w_slice       = acc_q[AW-1:CW];
  assign w_unused_lsbs = ^acc_q[CW-1:0];

  always_comb begin
    w_y_sat = w_slice[DW-1:0];
    if (!((&w_slice[SW-1:DW-1]) || ~(|w_slice[SW-1:DW-1]))) begin
      w_y_sat = w_slice[SW-1] ? {1'b1, {(DW-1){1'b0}}}
                              : {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign w_addr_ok = (32'(bus.coef_addr) < M);
  assign w_overrun = bus.sam_clk_en && busy_q;
  assign w_collide = bus.coef_we && busy_q && w_addr_ok;
  assign w_coef_wr = bus.coef_we && !busy_q && w_addr_ok;

  // A set event in the same cycle as err_clr keeps the bit set.
  always_comb begin
    err_d = err_q;
    if (bus.err_clr) err_d = '0;
    if (w_overrun)   err_d[0] = 1'b1;
    if (w_collide)   err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      j_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= '0;
      for (int i = 0; i < NTAPS; i++) x_q[i]    <= '0;
      for (int i = 0; i < M; i++)     b_q[i]    <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      y_valid_q <= 1'b0;
      err_q     <= err_d;
      if (w_coef_wr) b_q[bus.coef_addr] <= bus.coef_wdata;

      case (state_q)
        IDLE, OUT: begin
          if (state_q == OUT) begin
            y_q       <= w_y_sat;
            y_valid_q <= 1'b1;
          end
          // OUT doubles as an accept slot so samples can arrive back to back.
          if (bus.sam_clk_en) begin
            x_q[0] <= bus.x_in;
            for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
            acc_q   <= ROUNDK;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          for (int l = 0; l < LANES; l++) prod_q[l] <= w_prod[l];
          // prod_q holds the previous slot's products from the second slot on.
          if (j_q != '0) acc_q <= acc_q + w_sum;
          j_q <= j_q + 1'b1;
          if (j_q == JW'(P - 1)) state_q <= ACC;
        end
        ACC: begin
          acc_q   <= acc_q + w_sum;
          busy_q  <= 1'b0;
          state_q <= OUT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

`default_nettype wire
